// File: rtl/parking_pkg.sv
// parking_pkg: shared FSM encoding and sizing constants for the parking log arbiter.
package parking_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
    localparam int NREQ = 4;
    localparam int DEPTH = 16;
    localparam int DEST_P = 0;
    localparam int DEST_Q = 1;
    localparam logic REGION_P = 1'b0;
    localparam logic REGION_Q = 1'b1;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin search starting one past the last winner, wrapping modulo 4.
module rr_picker (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);
    always_comb begin
        valid = |req;
        idx = last;
        // Descending scan so the nearest requester after last overrides farther ones.
        for (int k = 4; k >= 1; k--)
            if (req[2'(last + 2'(k))]) idx = 2'(last + 2'(k));
    end
endmodule

// File: rtl/parking_log_arbiter.sv
// parking_log_arbiter: serialises gate time records into P/Q log regions of a shared memory.
// Optional PARKING_LOG_WRAP_EN: writes to a full region overwrite the oldest entry instead of nacking.
module parking_log_arbiter
    import parking_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dest,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   nack,
    output logic              mem_we,
    output logic [4:0]        mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [4:0]        p_count,
    output logic [4:0]        q_count,
    output logic              p_full,
    output logic              q_full,
    output logic              busy
);
    state_t     state;
    logic [1:0] last, win, idx;
    logic       win_dest, refused, valid, write_ok;
    logic [7:0] win_data;
    logic [3:0] p_ptr, q_ptr;

    rr_picker u_pick (.req(req), .last(last), .valid(valid), .idx(idx));

`ifdef PARKING_LOG_WRAP_EN
    assign write_ok = 1'b1;
`else
    assign write_ok = win_dest ? !q_full : !p_full;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            last <= 2'd3;
            win <= '0;
            win_dest <= 1'b0;
            win_data <= '0;
            refused <= 1'b0;
            p_ptr <= '0;
            q_ptr <= '0;
            p_count <= '0;
            q_count <= '0;
            p_full <= 1'b0;
            q_full <= 1'b0;
            ack <= '0;
            nack <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            busy <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            ack <= '0;
            nack <= '0;
            case (state)
                IDLE: if (valid) begin
                    win <= idx;
                    last <= idx;
                    win_dest <= dest[idx];
                    win_data <= req_data[{idx, 3'b000} +: 8];
                    busy <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    refused <= !write_ok;
                    state <= RESP;
                    if (write_ok) begin
                        mem_we <= 1'b1;
                        mem_addr <= {win_dest, win_dest == REGION_Q ? q_ptr : p_ptr};
                        mem_wdata <= win_data;
                        // When full, the pointer sits on the oldest entry, so advancing it overwrites in order.
                        if (win_dest == REGION_Q) begin
                            q_ptr <= q_ptr + 4'd1;
                            if (!q_full) begin
                                q_count <= q_count + 5'd1;
                                q_full <= (q_count + 5'd1) == 5'(DEPTH);
                            end
                        end else begin
                            p_ptr <= p_ptr + 4'd1;
                            if (!p_full) begin
                                p_count <= p_count + 5'd1;
                                p_full <= (p_count + 5'd1) == 5'(DEPTH);
                            end
                        end
                    end
                end
                RESP: begin
                    ack[win] <= !refused;
                    nack[win] <= refused;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parking_log_arbiter.sv
// tb_parking_log_arbiter: directed and randomized checks of parking_log_arbiter against a behavioural model.
module tb_parking_log_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req, dest, ack, nack;
    logic [31:0] req_data;
    logic        mem_we, p_full, q_full, busy;
    logic [4:0]  mem_addr, p_count, q_count;
    logic [7:0]  mem_wdata;

    int n_checks = 0;
    int n_fail = 0;
    int m_last;
    int m_cnt [2];
    int m_wr [2];

    parking_log_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .dest(dest), .req_data(req_data),
        .ack(ack), .nack(nack), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .p_count(p_count), .q_count(q_count), .p_full(p_full), .q_full(q_full), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        if (!reset) begin
            n_checks++;
            if ((int'(mem_we) + int'(|ack) + int'(|nack)) > 1 || $countones(ack) > 1 || $countones(nack) > 1) begin
                n_fail++;
                $display("FAIL exclusive: mem_we=%b ack=%b nack=%b, required at most one one-hot strobe", mem_we, ack, nack);
            end
        end
    end

    task automatic model_reset();
        m_last = 3;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_wr[0] = 0; m_wr[1] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Observes one transaction already presented on req; records what the DUT did, without judging it.
    task automatic run_grant(input bit drop, output int g, output bit we, output logic [4:0] a,
                             output logic [7:0] d, output bit acked, output bit nacked,
                             output bit to, output int we_cyc, output int ak_cyc);
        g = -1; we = 0; a = '0; d = '0; acked = 0; nacked = 0; to = 1; we_cyc = -1; ak_cyc = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (mem_we) begin we = 1; a = mem_addr; d = mem_wdata; we_cyc = c; end
            if (|ack || |nack) begin
                acked = |ack;
                nacked = |nack;
                for (int i = 0; i < 4; i++) if (ack[i] || nack[i]) g = i;
                to = 0;
                ak_cyc = c;
                if (drop) req[g] = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ack, nack, mem_we, mem_addr, mem_wdata, p_count, q_count, p_full, q_full, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b nack=%b we=%b addr=%h wdata=%h pc=%0d qc=%0d pf=%b qf=%b busy=%b, required all 0",
                     ack, nack, mem_we, mem_addr, mem_wdata, p_count, q_count, p_full, q_full, busy);
        end
    endtask

    task automatic test_single();
        int g, wc, kc; bit we, ak, nk, to; logic [4:0] a; logic [7:0] d;
        dest = 4'b0000; req_data = 32'h0000_00F3; req = 4'b0001;
        run_grant(1, g, we, a, d, ak, nk, to, wc, kc);
        n_checks++;
        if (to || g !== 0 || !ak || nk) begin
            n_fail++;
            $display("FAIL single_ack: timeout=%b gate=%0d ack=%b nack=%b, required gate 0 acked", to, g, ak, nk);
        end
        n_checks++;
        if (!we || a !== 5'h00 || d !== 8'hF3) begin
            n_fail++;
            $display("FAIL single_write: we=%b addr=%h data=%h, required we=1 addr=00 data=F3", we, a, d);
        end
        n_checks++;
        if (wc !== 1 || kc !== 2) begin
            n_fail++;
            $display("FAIL single_latency: we after edge %0d ack after edge %0d, required 2 and 3", wc + 1, kc + 1);
        end
        n_checks++;
        if (p_count !== 5'd1 || q_count !== 5'd0) begin
            n_fail++;
            $display("FAIL single_count: p_count=%0d q_count=%0d, required 1 and 0", p_count, q_count);
        end
    endtask

    task automatic test_round_robin();
        int g, wc, kc; bit we, ak, nk, to; logic [4:0] a; logic [7:0] d;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        dest = 4'b1111; req_data = 32'hD4C3_B2A1; req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            run_grant(0, g, we, a, d, ak, nk, to, wc, kc);
            n_checks++;
            if (to || g !== order[n] || !ak || !we || a !== 5'(16 + n) || d !== req_data[8*order[n] +: 8]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: gate=%0d ack=%b we=%b addr=%h data=%h, required gate %0d addr %h data %h",
                         n, g, ak, we, a, d, order[n], 5'(16 + n), req_data[8*order[n] +: 8]);
            end
        end
        req = '0;
        n_checks++;
        if (q_count !== 5'd5 || p_count !== 5'd0) begin
            n_fail++;
            $display("FAIL rr_count: q_count=%0d p_count=%0d, required 5 and 0", q_count, p_count);
        end
        @(negedge clock);
    endtask

    task automatic test_full();
        int g, wc, kc; bit we, ak, nk, to; logic [4:0] a; logic [7:0] d;
        do_reset();
        dest = 4'b0000;
        for (int n = 0; n < 16; n++) begin
            req_data = {24'h0, 8'(8'h40 + n)}; req = 4'b0001;
            run_grant(1, g, we, a, d, ak, nk, to, wc, kc);
            n_checks++;
            if (to || !ak || !we || a !== 5'(n) || d !== 8'(8'h40 + n) || p_full !== (n == 15) || p_count !== 5'(n + 1)) begin
                n_fail++;
                $display("FAIL fill%0d: ack=%b we=%b addr=%h data=%h full=%b count=%0d, required ack addr %h full %b count %0d",
                         n, ak, we, a, d, p_full, p_count, 5'(n), n == 15, n + 1);
            end
        end
        req_data = 32'h0000_00EE; req = 4'b0001;
        run_grant(1, g, we, a, d, ak, nk, to, wc, kc);
        n_checks++;
`ifdef PARKING_LOG_WRAP_EN
        if (to || !ak || nk || !we || a !== 5'h00 || d !== 8'hEE) begin
            n_fail++;
            $display("FAIL full_17th: ack=%b nack=%b we=%b addr=%h data=%h, required ack, write to 00 data EE", ak, nk, we, a, d);
        end
`else
        if (to || ak || !nk || we || g !== 0) begin
            n_fail++;
            $display("FAIL full_17th: ack=%b nack=%b we=%b gate=%0d, required nack on gate 0 and no write", ak, nk, we, g);
        end
`endif
        n_checks++;
        if (p_count !== 5'd16 || !p_full || q_full) begin
            n_fail++;
            $display("FAIL full_sat: p_count=%0d p_full=%b q_full=%b, required 16, 1, 0", p_count, p_full, q_full);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        dest = 4'b0000; req_data = 32'h0000_5500; req = 4'b0010;
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clock);
            if (mem_we) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midreset_we: mem_we=0 within bound, required write strobe");
        end
        reset = 1'b1; req = '0;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if ({ack, nack, mem_we, mem_addr, mem_wdata, p_count, q_count, p_full, q_full, busy} !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: ack=%b we=%b addr=%h pc=%0d busy=%b, required all 0", ack, mem_we, mem_addr, p_count, busy);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (|ack || |nack || mem_we) seen = 1;
        end
        n_checks++;
        if (seen || p_count !== 5'd0) begin
            n_fail++;
            $display("FAIL midreset_drop: late strobe=%b p_count=%0d, required no strobe and 0", seen, p_count);
        end
        model_reset();
    endtask

    task automatic test_drop();
        int g, wc, kc; bit we, ak, nk, to; logic [4:0] a; logic [7:0] d;
        do_reset();
        dest = 4'b0000; req_data = 32'h3300_2200; req = 4'b1100;
        @(negedge clock);
        req = 4'b1000;
        run_grant(0, g, we, a, d, ak, nk, to, wc, kc);
        n_checks++;
        if (to || g !== 2 || !ak || !we || a !== 5'h00 || d !== 8'h00) begin
            n_fail++;
            $display("FAIL drop_gate2: gate=%0d ack=%b we=%b addr=%h data=%h, required gate 2 ack addr 00 data 00", g, ak, we, a, d);
        end
        run_grant(1, g, we, a, d, ak, nk, to, wc, kc);
        n_checks++;
        if (to || g !== 3 || !ak || a !== 5'h01 || d !== 8'h33) begin
            n_fail++;
            $display("FAIL drop_next: gate=%0d ack=%b addr=%h data=%h, required gate 3 addr 01 data 33", g, ak, a, d);
        end
    endtask

    task automatic test_random();
        int g, wc, kc, w, rg, exp_addr; bit we, ak, nk, to, ew; logic [4:0] a; logic [7:0] d, exp_data;
        do_reset();
        for (int it = 0; it < 70; it++) begin
            req = 4'($urandom_range(0, 15));
            dest = 4'($urandom);
            req_data = $urandom;
            if (req == 4'b0000) begin
                @(negedge clock);
                n_checks++;
                if (busy || mem_we) begin
                    n_fail++;
                    $display("FAIL rand_idle%0d: busy=%b we=%b, required 0 with no request", it, busy, mem_we);
                end
                continue;
            end
            w = -1;
            for (int k = 4; k >= 1; k--) if (req[(m_last + k) % 4]) w = (m_last + k) % 4;
            rg = int'(dest[w]);
            exp_data = req_data[8*w +: 8];
`ifdef PARKING_LOG_WRAP_EN
            ew = 1;
`else
            ew = m_cnt[rg] < 16;
`endif
            exp_addr = rg * 16 + m_wr[rg] % 16;
            run_grant(1, g, we, a, d, ak, nk, to, wc, kc);
            if (ew) begin
                m_wr[rg]++;
                if (m_cnt[rg] < 16) m_cnt[rg]++;
            end
            m_last = w;
            n_checks++;
            if (to || g !== w || we !== ew || ak !== ew || nk !== !ew || (ew && (a !== 5'(exp_addr) || d !== exp_data))) begin
                n_fail++;
                $display("FAIL rand_txn%0d: gate=%0d we=%b ack=%b nack=%b addr=%h data=%h, required gate %0d we %b addr %h data %h",
                         it, g, we, ak, nk, a, d, w, ew, 5'(exp_addr), exp_data);
            end
            n_checks++;
            if (p_count !== 5'(m_cnt[0]) || q_count !== 5'(m_cnt[1]) || p_full !== (m_cnt[0] == 16) || q_full !== (m_cnt[1] == 16)) begin
                n_fail++;
                $display("FAIL rand_count%0d: pc=%0d qc=%0d pf=%b qf=%b, required %0d %0d", it, p_count, q_count, p_full, q_full, m_cnt[0], m_cnt[1]);
            end
        end
        req = '0;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; req = '0; dest = '0; req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_reset_mid();
        test_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/parking_log_arbiter.md
PARKING_LOG_ARBITER -- requirements
Module: parking_log_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of gate requesters; fixed at 4 in this revision.
REQ-002 Parameter DEPTH, default 16: entries per log region (P and Q); a power of two.
REQ-003 Ports: clock  in  1  single clock; all state changes on its rising edge.
REQ-004 Ports: reset  in  1  synchronous, active-high reset.
REQ-005 Ports: req  in  4  per-gate write request, level, held until ack or nack.
REQ-006 Ports: dest  in  4  per-gate target region; 0 = P log (enable_P traffic), 1 = Q log (enable_Q traffic).
REQ-007 Ports: req_data  in  32  per-gate 8-bit time record; gate i uses bits [8i+7:8i].
REQ-008 Ports: ack  out  4  one-hot, one-cycle pulse: write committed for that gate.
REQ-009 Ports: nack  out  4  one-hot, one-cycle pulse: write refused because the region is full.
REQ-010 Ports: mem_we  out  1  shared log memory write strobe.
REQ-011 Ports: mem_addr  out  5  {region bit, 4-bit entry pointer}.
REQ-012 Ports: mem_wdata  out  8  record written.
REQ-013 Ports: p_count, q_count  out  5 each  entries held per region, range 0..16.
REQ-014 Ports: p_full, q_full  out  1 each  count == DEPTH; busy  out  1  FSM not in IDLE.

Function
REQ-015 All outputs shall be registered.
REQ-016 The FSM shall have the states IDLE, WRITE and RESP.
REQ-017 In IDLE with any req bit high, the FSM shall latch the round-robin winner index, its dest and its data, then enter WRITE; otherwise it shall stay in IDLE.
REQ-018 Round-robin: search starts at the index after the last winner and wraps modulo 4; only a granted transaction updates the last winner.
REQ-019 In WRITE with the target region not full, the block shall assert mem_we for exactly one cycle, with mem_addr = {dest, ptr} and mem_wdata = latched data, then increment that region's ptr (mod 16) and count.
REQ-020 In WRITE with the target region full, there shall be no mem_we and no pointer or count change; the transaction shall be marked refused.
REQ-021 RESP shall pulse ack[winner] (committed) or nack[winner] (refused) for one cycle, then return to IDLE.
REQ-022 Latency: req sampled in IDLE at edge n -> mem_we high after edge n+1 -> ack high after edge n+2; minimum spacing between grants is 3 cycles.
REQ-023 A requester that drops req after being latched shall still have its transaction completed; req is next sampled only in IDLE.
REQ-024 A requester shall deassert req in the cycle after ack or nack; a held req shall be treated as a new request.
REQ-025 Simultaneous requests to different regions shall still be serialised, one per grant.
REQ-026 mem_we, ack and nack shall never be high in the same cycle.
REQ-027 Counts shall saturate at DEPTH and never wrap to 0.

Reset
REQ-028 Reset shall take priority over all other inputs on any edge, including mid-transaction; a pending write is dropped with no ack.
REQ-029 Reset values: state = IDLE; all outputs = 0; both pointers = 0; both counts = 0; last winner = 3, so gate 0 has first priority.

Configuration
REQ-030 Macro PARKING_LOG_WRAP_EN: when defined, a write to a full region shall still occur, overwriting the oldest entry; it is acked, nack is never asserted, and the count stays at 16 with full asserted.
REQ-031 Without PARKING_LOG_WRAP_EN, REQ-020 applies: writes to a full region are refused with nack.

Structure
REQ-032 Shared package parking_pkg shall hold: state encoding, NREQ, DEPTH, DEST_P = 0, DEST_Q = 1, REGION_P = 1'b0, REGION_Q = 1'b1.
REQ-033 The round-robin priority search shall be a separate combinational sub-module rr_picker, with inputs req[3:0] and last[1:0] and outputs valid and idx[1:0].

Verification
REQ-034 After reset, req = 4'b0001, dest = 0, data0 = 8'hF3 -> mem_we with addr 5'h00 and wdata F3 after edge 2; ack = 4'b0001 after edge 3; p_count = 1.
REQ-035 req = 4'b1111 held, all dest = 1 -> grant order 0, 1, 2, 3, 0; Q addresses 5'h10, 5'h11, 5'h12, 5'h13, 5'h14.
REQ-036 Sixteen P writes, then one more -> p_full = 1; the 17th returns nack with no mem_we (without the macro); with PARKING_LOG_WRAP_EN it writes addr 5'h00 and acks.
REQ-037 reset asserted in the cycle mem_we is high -> next cycle all outputs are 0, no ack, and the counts are unchanged from their pre-transaction value of 0.
REQ-038 Gate 2 drops req one cycle after being latched -> the write and ack[2] still occur; the next grant goes to gate 3 if it is requesting.
